// File: rtl/addsub_multiword_seq_addsub_bin.sv
// Single-word binary adder/subtractor with an explicit ripple carry chain.
// The carry chain is exposed so signed overflow can be derived from the
// carry into and out of the most significant bit.
module addsub_bin #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH:0]   carries
);

  logic [WIDTH-1:0] b_eff;

  // Ripple chain: carries[i] is the carry into bit i, carries[WIDTH] the carry out.
  always_comb begin
    b_eff      = add_sub ? ~b : b;
    carries    = '0;
    sum        = '0;
    carries[0] = add_sub ? ~carry_in : carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carries[i];
      carries[i+1] = (a[i] & b_eff[i]) | (a[i] & carries[i]) | (b_eff[i] & carries[i]);
    end
  end

  assign carry_out = carries[WIDTH];
  assign overflow  = carries[WIDTH] ^ carries[WIDTH-1];

endmodule

// File: rtl/addsub_multiword_seq.sv
// Multi-precision add/subtract sequencer: one word per accepted operand beat,
// least-significant word first, with the carry chained in a register between
// beats and a single registered result stage on the output stream.
module addsub_multiword_seq #(
  parameter int WORD_WIDTH = 20,
  parameter int WORD_COUNT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_add_sub,
  input  logic                  cmd_carry_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_A,
  input  logic [WORD_WIDTH-1:0] in_B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_sum,
  output logic                  out_last,
  output logic                  out_carry_out,
  output logic                  out_overflow,
  output logic                  busy
);

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;
  localparam int   CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      count;
  logic                  carry;
  logic                  mode;
  logic                  cmd_fire;
  logic                  in_fire;
  logic                  last_beat;
  logic [WORD_WIDTH-1:0] b_eff;
  logic [WORD_WIDTH-1:0] beat_sum;
  logic                  beat_carry;
  logic                  beat_ovf;
  logic [WORD_WIDTH:0]   carries_unused;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_beat = (count == LAST_IDX);

  // Subtraction is A + ~B + ~borrow; the inversion of B happens here so the
  // shared adder always runs in add mode.
  assign b_eff = mode ? ~in_B : in_B;

  addsub_bin #(
    .WIDTH(WORD_WIDTH)
  ) u_addsub_bin (
    .a         (in_A),
    .b         (b_eff),
    .add_sub   (ZERO),
    .carry_in  (carry),
    .sum       (beat_sum),
    .carry_out (beat_carry),
    .overflow  (beat_ovf),
    .carries   (carries_unused)
  );

  // Next-state and handshake outputs; the operand side only opens when the
  // result register is empty or being drained this cycle.
  always_comb begin
    state_next = state;
    cmd_ready  = ZERO;
    in_ready   = ZERO;
    busy       = ZERO;
    case (state)
      IDLE: begin
        cmd_ready = ONE;
        if (cmd_valid) state_next = RUN;
      end
      RUN: begin
        busy     = ONE;
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready) && last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Operation context: mode, word counter and the inter-beat carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode  <= ZERO;
      count <= '0;
      carry <= ZERO;
    end else if (cmd_fire) begin
      mode  <= cmd_add_sub;
      count <= '0;
      carry <= cmd_add_sub ? ~cmd_carry_in : cmd_carry_in;
    end else if (in_fire) begin
      carry <= beat_carry;
      count <= last_beat ? '0 : count + CNT_W'(1);
    end
  end

  // Result register: loads on each accepted beat, holds under backpressure,
  // and is replaced without a bubble when drain and refill coincide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= ZERO;
      out_sum       <= '0;
      out_last      <= ZERO;
      out_carry_out <= ZERO;
      out_overflow  <= ZERO;
    end else if (in_fire) begin
      out_valid     <= ONE;
      out_sum       <= beat_sum;
      out_last      <= last_beat;
      out_carry_out <= last_beat ? (mode ? ~beat_carry : beat_carry) : ZERO;
      out_overflow  <= last_beat ? beat_ovf : ZERO;
    end else if (out_ready) begin
      out_valid <= ZERO;
    end
  end

endmodule

// File: tb/tb_addsub_multiword_seq.sv
// Directed bench for addsub_multiword_seq with 8-bit words, two words per op.
module tb_addsub_multiword_seq;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_add_sub;
  logic         cmd_carry_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_carry_out;
  logic         out_overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  addsub_multiword_seq #(
    .WORD_WIDTH(W),
    .WORD_COUNT(2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_add_sub   (cmd_add_sub),
    .cmd_carry_in  (cmd_carry_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_A          (in_A),
    .in_B          (in_B),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_last      (out_last),
    .out_carry_out (out_carry_out),
    .out_overflow  (out_overflow),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Runs one two-word operation with out_ready held high, capturing each
  // result beat at the falling edge after the beat is accepted.
  task automatic op2(input logic mode, input logic cin,
                     input logic [15:0] a, input logic [15:0] b,
                     output logic [W-1:0] s0, output logic [W-1:0] s1,
                     output logic v0, output logic v1,
                     output logic l0, output logic l1,
                     output logic co0, output logic co, output logic ov);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_add_sub = mode; cmd_carry_in = cin;
    @(negedge clock);
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_A = a[7:0]; in_B = b[7:0];
    @(negedge clock);
    v0 = out_valid; s0 = out_sum; l0 = out_last; co0 = out_carry_out;
    in_A = a[15:8]; in_B = b[15:8];
    @(negedge clock);
    v1 = out_valid; s1 = out_sum; l1 = out_last; co = out_carry_out; ov = out_overflow;
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b want=1", cmd_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_sum !== 8'h00) begin bad++; $display("FAIL rst_out_sum got=%h want=00", out_sum); end
  endtask

  task automatic test_arith(input string name, input logic mode, input logic cin,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic eco, input logic eov);
    logic [W-1:0] s0, s1;
    logic v0, v1, l0, l1, co0, co, ov;
    op2(mode, cin, a, b, s0, s1, v0, v1, l0, l1, co0, co, ov);
    total++; if (v0 !== 1'b1 || s0 !== e0) begin bad++; $display("FAIL %s_w0 got=%b/%h want=1/%h", name, v0, s0, e0); end
    total++; if (v1 !== 1'b1 || s1 !== e1) begin bad++; $display("FAIL %s_w1 got=%b/%h want=1/%h", name, v1, s1, e1); end
    total++; if (l0 !== 1'b0 || l1 !== 1'b1) begin bad++; $display("FAIL %s_last got=%b%b want=01", name, l0, l1); end
    total++; if (co0 !== 1'b0) begin bad++; $display("FAIL %s_co_w0 got=%b want=0", name, co0); end
    total++; if (co !== eco) begin bad++; $display("FAIL %s_carry got=%b want=%b", name, co, eco); end
    total++; if (ov !== eov) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, ov, eov); end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_drain got=%b%b want=00", name, out_valid, busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_add_sub = 1'b0; cmd_carry_in = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_A = 8'hFF; in_B = 8'h01;
    @(negedge clock);
    in_A = 8'h01; in_B = 8'h00;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_sum !== 8'h00) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/00", i, out_valid, out_sum); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h02 || out_last !== 1'b1) begin
      bad++; $display("FAIL bp_w1 got=%b/%h/%b want=1/02/1", out_valid, out_sum, out_last);
    end
    @(negedge clock);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b%b want=00", out_valid, busy); end
  endtask

  task automatic test_cmd_while_pending();
    @(negedge clock);
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_add_sub = 1'b0; cmd_carry_in = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_A = 8'h02; in_B = 8'h04;
    @(negedge clock);
    out_ready = 1'b1; in_A = 8'h01; in_B = 8'h03;
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h04 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL pend_idle got=%b/%h/%b want=1/04/1", out_valid, out_sum, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_add_sub = 1'b0; cmd_carry_in = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_A = 8'h01; in_B = 8'h01;
    #1;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'h04) begin
      bad++; $display("FAIL pend_wait got=%b/%b/%h want=1/0/04", busy, in_ready, out_sum);
    end
    out_ready = 1'b1;
    @(negedge clock);
    in_A = 8'h00; in_B = 8'h00;
    total++; if (out_sum !== 8'h02 || out_last !== 1'b0) begin bad++; $display("FAIL pend_w0 got=%h/%b want=02/0", out_sum, out_last); end
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (out_sum !== 8'h00 || out_last !== 1'b1) begin bad++; $display("FAIL pend_w1 got=%h/%b want=00/1", out_sum, out_last); end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_add_sub = 1'b0; cmd_carry_in = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_A = 8'h55; in_B = 8'h11;
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b%b want=11", out_valid, busy); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL abort_async got=%b%b%b%b want=0010", out_valid, busy, cmd_ready, in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_post got=%b%b want=00", out_valid, busy); end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_add_sub = 1'b0; cmd_carry_in = 1'b0;
    in_valid = 1'b0; in_A = '0; in_B = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_arith("add_carry", 1'b0, 1'b0, 16'h01FF, 16'h0001, 8'h00, 8'h02, 1'b0, 1'b0);
    test_arith("add_ovf",   1'b0, 1'b0, 16'h7FFF, 16'h0001, 8'h00, 8'h80, 1'b0, 1'b1);
    test_arith("sub_borrow",1'b1, 1'b0, 16'h0000, 16'h0001, 8'hFF, 8'hFF, 1'b1, 1'b0);
    test_arith("sub_ovf",   1'b1, 1'b0, 16'h8000, 16'h0001, 8'hFF, 8'h7F, 1'b0, 1'b1);
    test_arith("add_cin",   1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0);
    test_backpressure();
    test_cmd_while_pending();
    test_reset_abort();
    test_arith("add_after", 1'b0, 1'b0, 16'h0001, 16'h0001, 8'h02, 8'h00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
